rv_ctrl_fsm: RTL and testbench
==============================

Name: rv_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I core.
- It fetches instructions over a valid/ready instruction port, latches them into an internal IR, decodes them, and drives the 12-bit one-hot ALU opcode and operand selects into the datapath ALU.
- It reads the ALU Zero flag back to resolve branches, and sequences memory and register-file writeback.
- It is the initiator side of the ALU operation interface.

Parameters:
- RST_PC_SEL_UNUSED, 0, reserved; must remain 0. The reset PC is owned by the datapath.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- inst_req_valid  out  1  fetch request valid
- inst_req_ready  in  1  fetch request accepted
- inst_rsp_valid  in  1  instruction word valid
- inst_rsp_ready  out  1  ready to take instruction word
- inst  in  32  instruction word
- alu_op  out  12  one-hot: 0 add, 1 sub, 2 and, 3 or, 4 auipc, 5 xor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra, 11 lui
- alu_src_a_pc  out  1  1: ALU A = PC; 0: A = rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_zero  in  1  ALU Zero flag
- imm  out  32  sign-extended immediate (I/S/B/U/J format)
- rf_waddr  out  5  IR[11:7]
- rf_wen  out  1  register-file write enable
- wb_sel_mem  out  1  1: writeback from load data; 0: from latched ALU result
- pc_wen  out  1  PC write enable
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- mem_req_valid  out  1  data request valid
- mem_req_ready  in  1  data request accepted
- mem_we  out  1  1 store, 0 load
- mem_rsp_valid  in  1  load data valid
- mem_rsp_ready  out  1  ready for load data
- state  out  9  one-hot state, for debug
- retired  out  32  count of completed instructions

Behaviour:
- States (one-hot): INIT, IF, IW, ID, EX, ST, LD, RDW, WB.
- Reset (rst high at a clock edge, from any state including mid-handshake):
  - state=INIT, IR=0, retired=0.
  - All valid, ready and write-enable outputs are 0 while in INIT.
  - alu_op=0.
- INIT -> IF, unconditionally.
- IF: inst_req_valid=1. Move to IW on inst_req_ready; otherwise hold.
- IW: inst_rsp_ready=1. On inst_rsp_valid:
  - latch inst into IR;
  - pc_wen=1, pc_sel=00 (PC+4);
  - go to ID.
- ID: decode the IR.
  - Opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}, and inst==32'h00000013: go to IF and increment retired.
  - Otherwise go to EX.
- EX: alu_op is non-zero only in EX; it is exactly one-hot; the datapath latches the ALU result at the end of EX.
  - OP/OP-IMM, selected by funct3:
    - 000: add; OP with funct7[5]=1 gives sub.
    - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
    - 101: srl if funct7[5]=0, else sra (applies to both OP and OP-IMM).
    - alu_src_b is 00 for OP, 01 for OP-IMM.
  - LUI: lui, alu_src_b=01.
  - AUIPC: auipc, alu_src_a_pc=1, alu_src_b=01.
  - LOAD/STORE: add, alu_src_b=01.
  - JAL/JALR: add, alu_src_a_pc=1, alu_src_b=10. Also pc_wen=1 with pc_sel 01 (JAL) or 10 (JALR).
  - BRANCH, selected by funct3:
    - 000 and 001 use sub: beq taken when alu_zero=1, bne when alu_zero=0.
    - 100 and 101 use slt; 110 and 111 use sltu.
    - blt/bltu are taken when alu_zero=0; bge/bgeu when alu_zero=1.
    - If taken: pc_wen=1, pc_sel=01.
  - Next state from EX: BRANCH -> IF (retired+1); STORE -> ST; LOAD -> LD; all others -> WB.
- ST: mem_req_valid=1, mem_we=1. On mem_req_ready go to IF and increment retired.
- LD: mem_req_valid=1, mem_we=0. On mem_req_ready go to RDW.
- RDW: mem_rsp_ready=1. On mem_rsp_valid go to WB.
- WB:
  - rf_wen=1 only if rf_waddr != 0;
  - wb_sel_mem=1 only for loads;
  - go to IF and increment retired.
- Immediate:
  - imm is combinational from IR and stable from ID through the end of the instruction.
  - B and J immediates have bit0=0. U immediate = {IR[31:12], 12'b0}.
- retired wraps from 32'hFFFFFFFF to 0.
- At most one of pc_wen, rf_wen, mem_req_valid is high in any cycle.
- Valid signals stay high until accepted; rst is the only exception.

Test Plan:
- Reset, then rst=0 with inst_req_ready=1 -> INIT, IF, IW; inst_req_valid=1 in the IF cycle. retired=0.
- Fetch add x3,x1,x2 (32'h002081B3), responses immediate -> EX: alu_op=12'h001, alu_src_b=00. WB: rf_wen=1, rf_waddr=3. retired=1; 6 cycles from IF to next IF.
- Fetch sub x5,x6,x7 (32'h407302B3), then srai x1,x1,3 (32'h4030D093) -> alu_op=12'h002, then alu_op=12'h400 with alu_src_b=01 and imm=3.
- bne x1,x2,-8 (32'hFE209CE3) with alu_zero=0 -> EX: alu_op=12'h002, pc_wen=1, pc_sel=01, imm=32'hFFFFFFF8. With alu_zero=1 -> pc_wen=0 in EX.
- lw x4,8(x0) (32'h00802203) with mem_req_ready held low 3 cycles, then mem_rsp_valid delayed 2 cycles -> mem_req_valid stays high throughout the stall. WB: wb_sel_mem=1, rf_wen=1.
- rst asserted in RDW; also addi x0,x0,5 (32'h00500013) -> the rst case returns to INIT with mem_rsp_ready=0 next cycle. The addi gives alu_op=12'h001 and rf_wen=0 in WB because rd=0.

Source files
------------

// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle control unit for an RV32I core.
// Fetches an instruction over a valid/ready port, latches it into IR and
// decodes it. It then drives the one-hot ALU opcode and the operand selects,
// resolves branches from the ALU Zero flag, and sequences the load/store and
// register-file writeback.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   inst_req_*/inst_rsp_*, inst       instruction fetch handshake + word
//   alu_op, alu_src_a_pc, alu_src_b   ALU operation and operand selects (EX only)
//   alu_zero                          ALU Zero flag, used for branch resolution
//   imm                               immediate decoded from IR
//   rf_waddr, rf_wen, wb_sel_mem      register-file writeback control
//   pc_wen, pc_sel                    PC update control
//   mem_req_*/mem_rsp_*, mem_we       data memory handshake
//   state, retired                    one-hot debug state, retired-instr count
module rv_ctrl_fsm #(
  parameter int RST_PC_SEL_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req_valid,
  input  logic        inst_req_ready,
  input  logic        inst_rsp_valid,
  output logic        inst_rsp_ready,
  input  logic [31:0] inst,
  output logic [11:0] alu_op,
  output logic        alu_src_a_pc,
  output logic [1:0]  alu_src_b,
  input  logic        alu_zero,
  output logic [31:0] imm,
  output logic [4:0]  rf_waddr,
  output logic        rf_wen,
  output logic        wb_sel_mem,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  output logic [8:0]  state,
  output logic [31:0] retired
);

  // The reset PC lives in the datapath; this parameter is reserved and stays 0.
  if (RST_PC_SEL_UNUSED != 0) begin : g_param_chk
    $error("rv_ctrl_fsm: RST_PC_SEL_UNUSED must be 0");
  end

  // One-hot state bit positions.
  localparam int S_INIT = 0, S_IF = 1, S_IW = 2, S_ID = 3, S_EX = 4,
                 S_ST = 5, S_LD = 6, S_RDW = 7, S_WB = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Bit positions inside the one-hot alu_op.
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_AUIPC = 4'd4, A_XOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
                         A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10, A_LUI = 4'd11;

  logic [8:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign alt = ir_q[30];

  logic       op_legal;
  logic [3:0] alu_idx;
  logic       src_a_pc_ex;
  logic [1:0] src_b_ex;
  logic       pc_wen_ex;
  logic [1:0] pc_sel_ex;

  // EX-stage decode of IR; only consumed while in EX.
  always_comb begin : decode
    op_legal    = 1'b1;
    alu_idx     = A_ADD;
    src_a_pc_ex = 1'b0;
    src_b_ex    = 2'b00;
    pc_wen_ex   = 1'b0;
    pc_sel_ex   = 2'b00;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        case (f3)
          3'b000:  alu_idx = (opc == OPC_OP && alt) ? A_SUB : A_ADD;
          3'b001:  alu_idx = A_SLL;
          3'b010:  alu_idx = A_SLT;
          3'b011:  alu_idx = A_SLTU;
          3'b100:  alu_idx = A_XOR;
          3'b101:  alu_idx = alt ? A_SRA : A_SRL;
          3'b110:  alu_idx = A_OR;
          default: alu_idx = A_AND;
        endcase
        src_b_ex = (opc == OPC_OPIMM) ? 2'b01 : 2'b00;
      end
      OPC_LUI: begin
        alu_idx  = A_LUI;
        src_b_ex = 2'b01;
      end
      OPC_AUIPC: begin
        alu_idx     = A_AUIPC;
        src_a_pc_ex = 1'b1;
        src_b_ex    = 2'b01;
      end
      OPC_LOAD, OPC_STORE: src_b_ex = 2'b01;
      OPC_JAL, OPC_JALR: begin
        // ALU forms the link address PC+4 while the PC takes the target.
        src_a_pc_ex = 1'b1;
        src_b_ex    = 2'b10;
        pc_wen_ex   = 1'b1;
        pc_sel_ex   = (opc == OPC_JAL) ? 2'b01 : 2'b10;
      end
      OPC_BRANCH: begin
        // slt/sltu produce 1 when "less than", so Zero means "not less".
        case (f3)
          3'b000:  begin alu_idx = A_SUB;  pc_wen_ex = alu_zero;  end
          3'b001:  begin alu_idx = A_SUB;  pc_wen_ex = !alu_zero; end
          3'b100:  begin alu_idx = A_SLT;  pc_wen_ex = !alu_zero; end
          3'b101:  begin alu_idx = A_SLT;  pc_wen_ex = alu_zero;  end
          3'b110:  begin alu_idx = A_SLTU; pc_wen_ex = !alu_zero; end
          3'b111:  begin alu_idx = A_SLTU; pc_wen_ex = alu_zero;  end
          default: alu_idx = A_SUB;
        endcase
        pc_sel_ex = pc_wen_ex ? 2'b01 : 2'b00;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Immediate, combinational from IR so it holds for the whole instruction.
  always_comb begin : imm_gen
    imm = 32'd0;
    case (opc)
      // Shift immediates carry funct7 in the I-field; expose only shamt.
      OPC_OPIMM: imm = (f3 == 3'b001 || f3 == 3'b101) ? {27'd0, ir_q[24:20]}
                                                       : {{20{ir_q[31]}}, ir_q[31:20]};
      OPC_LOAD, OPC_JALR: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      OPC_STORE:  imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ir_q[31:12], 12'd0};
      OPC_JAL:    imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:    imm = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= 9'd1 << S_INIT;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic.
  always_comb begin : next_state
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (1'b1)
      state_q[S_INIT]: state_d = 9'd1 << S_IF;
      state_q[S_IF]:   if (inst_req_ready) state_d = 9'd1 << S_IW;
      state_q[S_IW]: begin
        if (inst_rsp_valid) begin
          ir_d    = inst;
          state_d = 9'd1 << S_ID;
        end
      end
      state_q[S_ID]: begin
        if (!op_legal || ir_q == 32'h0000_0013) begin
          state_d   = 9'd1 << S_IF;
          retired_d = retired_q + 32'd1;
        end else begin
          state_d = 9'd1 << S_EX;
        end
      end
      state_q[S_EX]: begin
        case (opc)
          OPC_BRANCH: begin
            state_d   = 9'd1 << S_IF;
            retired_d = retired_q + 32'd1;
          end
          OPC_STORE: state_d = 9'd1 << S_ST;
          OPC_LOAD:  state_d = 9'd1 << S_LD;
          default:   state_d = 9'd1 << S_WB;
        endcase
      end
      state_q[S_ST]: begin
        if (mem_req_ready) begin
          state_d   = 9'd1 << S_IF;
          retired_d = retired_q + 32'd1;
        end
      end
      state_q[S_LD]:  if (mem_req_ready) state_d = 9'd1 << S_RDW;
      state_q[S_RDW]: if (mem_rsp_valid) state_d = 9'd1 << S_WB;
      state_q[S_WB]: begin
        state_d   = 9'd1 << S_IF;
        retired_d = retired_q + 32'd1;
      end
      default: state_d = 9'd1 << S_INIT;
    endcase
  end

  // Output logic.
  always_comb begin : outputs
    inst_req_valid = 1'b0;
    inst_rsp_ready = 1'b0;
    alu_op         = '0;
    alu_src_a_pc   = 1'b0;
    alu_src_b      = 2'b00;
    rf_wen         = 1'b0;
    wb_sel_mem     = 1'b0;
    pc_wen         = 1'b0;
    pc_sel         = 2'b00;
    mem_req_valid  = 1'b0;
    mem_we         = 1'b0;
    mem_rsp_ready  = 1'b0;
    case (1'b1)
      state_q[S_IF]: inst_req_valid = 1'b1;
      state_q[S_IW]: begin
        inst_rsp_ready = 1'b1;
        pc_wen         = inst_rsp_valid;
      end
      state_q[S_EX]: begin
        alu_op       = 12'd1 << alu_idx;
        alu_src_a_pc = src_a_pc_ex;
        alu_src_b    = src_b_ex;
        pc_wen       = pc_wen_ex;
        pc_sel       = pc_sel_ex;
      end
      state_q[S_ST]: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
      end
      state_q[S_LD]:  mem_req_valid = 1'b1;
      state_q[S_RDW]: mem_rsp_ready = 1'b1;
      state_q[S_WB]: begin
        rf_wen     = (ir_q[11:7] != 5'd0);
        wb_sel_mem = (opc == OPC_LOAD);
      end
      default: ;
    endcase
  end

  assign rf_waddr = ir_q[11:7];
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Scoreboard bench for rv_ctrl_fsm: the stimulus process issues instructions
// with random handshake delays and pushes expected EX/WB/retire records
// computed by a mnemonic-level reference model; a monitor pops and compares
// them when the DUT reaches EX, WB and each new fetch.
module tb_rv_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req_valid, inst_req_ready, inst_rsp_valid, inst_rsp_ready;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic        alu_src_a_pc;
  logic [1:0]  alu_src_b;
  logic        alu_zero;
  logic [31:0] imm;
  logic [4:0]  rf_waddr;
  logic        rf_wen, wb_sel_mem, pc_wen;
  logic [1:0]  pc_sel;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, mem_rsp_ready;
  logic [8:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  rv_ctrl_fsm #(.RST_PC_SEL_UNUSED(0)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_ready(inst_rsp_ready), .inst(inst),
    .alu_op(alu_op), .alu_src_a_pc(alu_src_a_pc), .alu_src_b(alu_src_b),
    .alu_zero(alu_zero), .imm(imm), .rf_waddr(rf_waddr), .rf_wen(rf_wen),
    .wb_sel_mem(wb_sel_mem), .pc_wen(pc_wen), .pc_sel(pc_sel),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .state(state), .retired(retired)
  );

  typedef struct packed {
    logic [11:0] op;
    logic        a_pc;
    logic [1:0]  b;
    logic [31:0] imm;
    logic        chk_imm;
    logic        pcw;
    logic [1:0]  pcs;
  } ex_t;
  typedef struct packed {
    logic       wen;
    logic [4:0] wa;
    logic       sel_mem;
  } wb_t;

  ex_t         ex_q[$];
  wb_t         wb_q[$];
  logic [31:0] ret_q[$];
  logic [31:0] exp_ret;
  int          vectors = 0, miscompares = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_stop(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return inst_req_valid;
      1:       return inst_rsp_ready;
      2:       return mem_req_valid;
      default: return mem_rsp_ready;
    endcase
  endfunction

  // Polls at posedge+1 until the selected DUT output is high, bounded.
  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!sig_sel(which)) begin
      if (n == 60) fail_stop(name);
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Reference model: describes the expected EX/WB behaviour per mnemonic.
  // kind: 0 no memory access, 1 store, 2 load.
  function automatic void model(input logic [31:0] ins, input logic z,
                                output logic has_ex, output ex_t e,
                                output logic has_wb, output wb_t w, output int kind);
    int          op_of_f3 [8] = '{0, 8, 6, 7, 5, 9, 3, 2};
    int          idx, off;
    logic [2:0]  f3;
    logic [6:0]  opc;
    f3  = ins[14:12];
    opc = ins[6:0];
    e = '0; w = '0; kind = 0; idx = 0;
    has_ex = 1'b1; has_wb = 1'b1;
    w.wen = (ins[11:7] != 5'd0);
    w.wa  = ins[11:7];
    e.chk_imm = 1'b1;
    case (opc)
      7'b0110011: begin  // OP
        idx = op_of_f3[f3];
        if (ins[30] && f3 == 3'd0) idx = 1;
        if (ins[30] && f3 == 3'd5) idx = 10;
        e.chk_imm = 1'b0;
      end
      7'b0010011: begin  // OP-IMM
        if (ins == 32'h0000_0013) begin
          has_ex = 1'b0; has_wb = 1'b0;
        end else begin
          idx = op_of_f3[f3];
          if (ins[30] && f3 == 3'd5) idx = 10;
          e.b = 2'b01;
          if (f3 == 3'd1 || f3 == 3'd5) e.imm = 32'(ins[24:20]);
          else e.imm = 32'($signed(ins) >>> 20);
        end
      end
      7'b0110111: begin idx = 11; e.b = 2'b01; e.imm = ins & 32'hFFFF_F000; end
      7'b0010111: begin idx = 4; e.a_pc = 1'b1; e.b = 2'b01; e.imm = ins & 32'hFFFF_F000; end
      7'b0000011: begin
        e.b = 2'b01; e.imm = 32'($signed(ins) >>> 20); kind = 2; w.sel_mem = 1'b1;
      end
      7'b0100011: begin
        e.b = 2'b01; has_wb = 1'b0; kind = 1;
        e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      end
      7'b1101111: begin
        e.a_pc = 1'b1; e.b = 2'b10; e.pcw = 1'b1; e.pcs = 2'b01;
        off = ins[31] ? -(1 << 20) : 0;
        off = off + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        e.imm = 32'(off);
      end
      7'b1100111: begin
        e.a_pc = 1'b1; e.b = 2'b10; e.pcw = 1'b1; e.pcs = 2'b10;
        e.imm = 32'($signed(ins) >>> 20);
      end
      7'b1100011: begin
        has_wb = 1'b0;
        case (f3)
          3'd0: begin idx = 1; e.pcw = z;  end  // beq
          3'd1: begin idx = 1; e.pcw = !z; end  // bne
          3'd4: begin idx = 6; e.pcw = !z; end  // blt
          3'd5: begin idx = 6; e.pcw = z;  end  // bge
          3'd6: begin idx = 7; e.pcw = !z; end  // bltu
          default: begin idx = 7; e.pcw = z; end  // bgeu
        endcase
        e.pcs = 2'b01;
        off = ins[31] ? -4096 : 0;
        off = off + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        e.imm = 32'(off);
      end
      default: begin has_ex = 1'b0; has_wb = 1'b0; end
    endcase
    e.op = 12'(1 << idx);
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        alt;
    logic [2:0]  bf [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    r   = $urandom;
    f3  = 3'($urandom_range(0, 7));
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    alt = (f3 == 3'd0 || f3 == 3'd5) && ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 10))
      0:  return {1'b0, alt, 5'd0, rs2, rs1, f3, rd, 7'b0110011};
      1:  if (f3 == 3'd1 || f3 == 3'd5)
            return {1'b0, alt && f3 == 3'd5, 5'd0, r[24:20], rs1, f3, rd, 7'b0010011};
          else
            return {r[31:20], rs1, f3, rd, 7'b0010011};
      2:  return {r[31:12], rd, 7'b0110111};
      3:  return {r[31:12], rd, 7'b0010111};
      4:  return {r[31:12], rd, 7'b1101111};
      5:  return {r[31:20], rs1, 3'd0, rd, 7'b1100111};
      6:  return {r[31:25], rs2, rs1, bf[$urandom_range(0, 5)], r[11:7], 7'b1100011};
      7:  return {r[31:20], rs1, f3, rd, 7'b0000011};
      8:  return {r[31:25], rs2, rs1, f3, r[11:7], 7'b0100011};
      9:  return 32'h0000_0013;
      default: return {r[31:2], 2'b00};  // low opcode bits 00: no RV32I opcode
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h001);
    chk({tag, "_inst_req_valid"}, 32'(inst_req_valid), 0);
    chk({tag, "_inst_rsp_ready"}, 32'(inst_rsp_ready), 0);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
    chk({tag, "_mem_rsp_ready"}, 32'(mem_rsp_ready), 0);
    chk({tag, "_rf_wen"}, 32'(rf_wen), 0);
    chk({tag, "_pc_wen"}, 32'(pc_wen), 0);
    chk({tag, "_alu_op"}, 32'(alu_op), 0);
    chk({tag, "_retired"}, retired, 0);
  endtask

  // Issues one instruction; all actions happen at posedge+1.
  task automatic run_inst(input logic [31:0] ins, input logic z, input int rq, input int rs,
                          input int mq, input int ms, input bit abort, output int t_if);
    logic has_ex, has_wb;
    ex_t  e;
    wb_t  w;
    int   kind;
    wait_for(0, "wait_if");
    t_if = cyc;
    model(ins, z, has_ex, e, has_wb, w, kind);
    alu_zero = z;
    repeat (rq) begin
      @(posedge clk); #1;
      chk("inst_req_hold", 32'(inst_req_valid), 1);
    end
    inst_req_ready = 1'b1;
    @(posedge clk); #1;
    inst_req_ready = 1'b0;
    wait_for(1, "wait_iw");
    repeat (rs) begin @(posedge clk); #1; end
    if (has_ex) ex_q.push_back(e);
    if (has_wb) wb_q.push_back(w);
    exp_ret = exp_ret + 32'd1;
    ret_q.push_back(exp_ret);
    inst_rsp_valid = 1'b1;
    inst = ins;
    #1;
    chk("iw_pc_wen", 32'(pc_wen), 1);
    chk("iw_pc_sel", 32'(pc_sel), 0);
    @(posedge clk); #1;
    inst_rsp_valid = 1'b0;
    inst = $urandom;
    if (kind != 0) begin
      wait_for(2, "wait_mem_req");
      repeat (mq) begin
        @(posedge clk); #1;
        chk("mem_req_hold", 32'(mem_req_valid), 1);
      end
      chk("mem_we", 32'(mem_we), 32'(kind == 1));
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (kind == 2) begin
        wait_for(3, "wait_rdw");
        if (abort) begin
          rst = 1'b1;
          ex_q.delete(); wb_q.delete(); ret_q.delete();
          exp_ret = 0;
          @(posedge clk); #1;
          check_idle("rdw_reset");
          ret_q.push_back(0);
          rst = 1'b0;
          return;
        end
        repeat (ms) begin @(posedge clk); #1; end
        mem_rsp_valid = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
      end
    end
  endtask

  // Monitor: compares DUT presentations against the scoreboard queues.
  initial begin
    logic  prev_if;
    ex_t   e;
    wb_t   w;
    logic [31:0] r;
    prev_if = 1'b0;
    forever begin
      @(negedge clk);
      chk("state_onehot", 32'($onehot(state)), 1);
      chk("strobe_exclusive", 32'(int'(pc_wen) + int'(rf_wen) + int'(mem_req_valid) <= 1), 1);
      if (state[4]) begin
        if (ex_q.size() == 0) chk("ex_unexpected", 32'(state), 0);
        else begin
          e = ex_q.pop_front();
          chk("ex_alu_op", 32'(alu_op), 32'(e.op));
          chk("ex_src_a_pc", 32'(alu_src_a_pc), 32'(e.a_pc));
          chk("ex_src_b", 32'(alu_src_b), 32'(e.b));
          chk("ex_pc_wen", 32'(pc_wen), 32'(e.pcw));
          if (e.pcw) chk("ex_pc_sel", 32'(pc_sel), 32'(e.pcs));
          if (e.chk_imm) chk("ex_imm", imm, e.imm);
        end
      end else begin
        chk("alu_op_idle", 32'(alu_op), 0);
      end
      if (state[8]) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 32'(state), 0);
        else begin
          w = wb_q.pop_front();
          chk("wb_rf_wen", 32'(rf_wen), 32'(w.wen));
          chk("wb_rf_waddr", 32'(rf_waddr), 32'(w.wa));
          chk("wb_sel_mem", 32'(wb_sel_mem), 32'(w.sel_mem));
        end
      end
      if (state[1] && !prev_if) begin
        if (ret_q.size() == 0) chk("ret_unexpected", retired, 32'hFFFF_FFFF);
        else begin
          r = ret_q.pop_front();
          chk("retired", retired, r);
        end
      end
      prev_if = state[1];
    end
  end

  initial begin
    int t0, t1, tx;
    inst_req_ready = 1'b0; inst_rsp_valid = 1'b0; inst = '0;
    alu_zero = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_ret = 0;
    repeat (2) @(posedge clk); #1;
    check_idle("reset");
    ret_q.push_back(0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("init_to_if_state", 32'(state), 32'h002);
    chk("init_to_if_req_valid", 32'(inst_req_valid), 1);

    run_inst(32'h002081B3, 1'b0, 0, 0, 0, 0, 1'b0, t0);  // add x3,x1,x2
    run_inst(32'h407302B3, 1'b0, 0, 0, 0, 0, 1'b0, t1);  // sub x5,x6,x7
    // IF,IW,ID,EX,WB then IF again: six cycles counting both IFs.
    chk("if_to_if_cycles", 32'(t1 - t0), 5);
    run_inst(32'h4030D093, 1'b0, 1, 1, 0, 0, 1'b0, tx);  // srai x1,x1,3
    run_inst(32'hFE209CE3, 1'b0, 0, 0, 0, 0, 1'b0, tx);  // bne taken
    run_inst(32'hFE209CE3, 1'b1, 0, 0, 0, 0, 1'b0, tx);  // bne not taken
    run_inst(32'h00802203, 1'b0, 0, 0, 3, 2, 1'b0, tx);  // lw x4,8(x0), stalled
    run_inst(32'h00500013, 1'b0, 0, 0, 0, 0, 1'b0, tx);  // addi x0,x0,5

    for (int i = 0; i < 200; i++)
      run_inst(gen_inst(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, tx);

    run_inst(32'h00802203, 1'b0, 0, 0, 1, 0, 1'b1, tx);  // lw, reset while in RDW
    run_inst(32'h002081B3, 1'b0, 0, 0, 0, 0, 1'b0, tx);
    wait_for(0, "final_if");
    @(negedge clk); #1;
    chk("ex_q_drained", 32'(ex_q.size()), 0);
    chk("wb_q_drained", 32'(wb_q.size()), 0);
    chk("ret_q_drained", 32'(ret_q.size()), 0);
    chk("final_retired", retired, exp_ret);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
